// File: rtl/pwm_led_array_if.sv
// Channel-settings write bus for the PWM LED array: one strobe carrying
// the target channel, the duty/peak value and the static/breathe mode.
interface pwm_led_array_if #(
    parameter int WIDTH = 8
);
    logic             WrEn;
    logic [3:0]       WrChan;
    logic [WIDTH-1:0] WrDuty;
    logic             WrMode;

    modport master (output WrEn, output WrChan, output WrDuty, output WrMode);
    modport slave  (input  WrEn, input  WrChan, input  WrDuty, input  WrMode);
endinterface

// File: rtl/pwm_led_array.sv
// Multi-channel LED PWM driver sharing one period counter; each channel runs
// either a static duty or a triangle "breathe" that steps once per period.
module pwm_led_array #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                SysClk,
    input  logic                ResetN,
    input  logic                Enable,
    pwm_led_array_if.slave      Wr,
    output logic [CHANNELS-1:0] PWM,
    output logic                PeriodStart
);

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dirT;

    localparam logic [WIDTH-1:0] MaxCount = '1;
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);

    logic [WIDTH-1:0] count;
    logic             boundary;

    logic [WIDTH-1:0] shadowDuty [CHANNELS];
    logic             shadowMode [CHANNELS];
    logic [WIDTH-1:0] activeDuty [CHANNELS];
    logic             activeMode [CHANNELS];
    dirT              dir        [CHANNELS];

    logic [WIDTH-1:0] nextActive [CHANNELS];
    dirT              nextDir    [CHANNELS];

    assign boundary = Enable && (count == MaxCount);

    // Value each channel would take at the next boundary. A channel entering
    // breathe from static steps upward from wherever its Active value sits.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            nextActive[i] = activeDuty[i];
            nextDir[i]    = dir[i];
            if (!shadowMode[i]) begin
                nextActive[i] = shadowDuty[i];
            end else if (!activeMode[i] || dir[i] == DirUp) begin
                if (activeDuty[i] >= shadowDuty[i]) begin
                    nextDir[i] = DirDown;
                    if (activeDuty[i] != '0)
                        nextActive[i] = activeDuty[i] - One;
                end else begin
                    nextDir[i]    = DirUp;
                    nextActive[i] = activeDuty[i] + One;
                end
            end else begin
                if (activeDuty[i] == '0) begin
                    nextDir[i] = DirUp;
                    if (shadowDuty[i] != '0)
                        nextActive[i] = One;
                end else begin
                    nextActive[i] = activeDuty[i] - One;
                end
            end
        end
    end

    // Shadow writes land immediately, but a write coinciding with a boundary
    // is only seen at the following one since the boundary reads old shadow.
    always_ff @(posedge SysClk) begin
        if (!ResetN) begin
            count       <= '0;
            PWM         <= '0;
            PeriodStart <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadowDuty[i] <= '0;
                shadowMode[i] <= 1'b0;
                activeDuty[i] <= '0;
                activeMode[i] <= 1'b0;
                dir[i]        <= DirUp;
            end
        end else begin
            if (Enable)
                count <= count + One;
            PeriodStart <= boundary;
            for (int i = 0; i < CHANNELS; i++) begin
                if (Wr.WrEn && (Wr.WrChan == 4'(i))) begin
                    shadowDuty[i] <= Wr.WrDuty;
                    shadowMode[i] <= Wr.WrMode;
                end
                if (boundary) begin
                    activeDuty[i] <= nextActive[i];
                    activeMode[i] <= shadowMode[i];
                    dir[i]        <= nextDir[i];
                end
                PWM[i] <= Enable && ((activeDuty[i] == MaxCount) || (count < activeDuty[i]));
            end
        end
    end

endmodule

// File: tb/tb_pwm_led_array.sv
// Directed self-checking bench for pwm_led_array (CHANNELS=4, WIDTH=8):
// per-period high counts are compared against hand-computed duty values.
module tb_pwm_led_array;

    logic       SysClk = 1'b0;
    logic       ResetN;
    logic       Enable;
    logic [3:0] PWM;
    logic       PeriodStart;

    pwm_led_array_if #(.WIDTH(8)) wr ();

    pwm_led_array #(.CHANNELS(4), .WIDTH(8)) dut (
        .SysClk      (SysClk),
        .ResetN      (ResetN),
        .Enable      (Enable),
        .Wr          (wr),
        .PWM         (PWM),
        .PeriodStart (PeriodStart)
    );

    always #5 SysClk = ~SysClk;

    int compared   = 0;
    int mismatched = 0;
    int highs [4];
    int expHighs [4];
    int psExtra;
    int elapsed;

    // Inputs change on the falling edge, right after that edge's sample.
    task automatic writeReg(input logic [3:0] ch, input logic [7:0] duty, input logic mode);
        wr.WrEn   = 1'b1;
        wr.WrChan = ch;
        wr.WrDuty = duty;
        wr.WrMode = mode;
        @(negedge SysClk);
        wr.WrEn   = 1'b0;
    endtask

    task automatic waitPeriodStart(output int el);
        el = 0;
        do begin
            @(negedge SysClk);
            el++;
        end while (!PeriodStart && el < 600);
        compared++;
        if (PeriodStart !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL waitPeriodStart: PeriodStart got %b want 1 within 600 clocks", PeriodStart);
        end
    endtask

    // Called on a PeriodStart sample; sample k then reflects Count=k-1.
    task automatic measurePeriod(input int wrAt, input logic [3:0] ch,
                                 input logic [7:0] duty, input logic mode);
        for (int c = 0; c < 4; c++) highs[c] = 0;
        psExtra = 0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge SysClk);
            for (int c = 0; c < 4; c++) if (PWM[c]) highs[c]++;
            if (k < 256 && PeriodStart) psExtra++;
            if (k == wrAt) begin
                wr.WrEn   = 1'b1;
                wr.WrChan = ch;
                wr.WrDuty = duty;
                wr.WrMode = mode;
            end else begin
                wr.WrEn = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        ResetN    = 1'b0;
        Enable    = 1'b1;
        wr.WrEn   = 1'b1;
        wr.WrChan = 4'd0;
        wr.WrDuty = 8'd99;
        wr.WrMode = 1'b0;
        repeat (3) @(negedge SysClk);
        compared++;
        if (PWM !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_pwm: got %b want 0000", PWM);
        end
        compared++;
        if (PeriodStart !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_periodstart: got %b want 0", PeriodStart);
        end
        compared++;
        if (dut.count !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_count: got %0d want 0", dut.count);
        end
        ResetN  = 1'b1;
        wr.WrEn = 1'b0;
        waitPeriodStart(elapsed);
        compared++;
        if (elapsed !== 256) begin
            mismatched++;
            $display("[TB] FAIL reset_first_period: got %0d clocks want 256", elapsed);
        end
        measurePeriod(-1, 4'd0, 8'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            compared++;
            if (highs[c] !== 0) begin
                mismatched++;
                $display("[TB] FAIL reset_write_dropped ch%0d: got %0d highs want 0", c, highs[c]);
            end
        end
    endtask

    task automatic test_static_duty;
        measurePeriod(10, 4'd0, 8'd64, 1'b0);
        compared++;
        if (highs[0] !== 0) begin
            mismatched++;
            $display("[TB] FAIL static_first_period: got %0d highs want 0", highs[0]);
        end
        for (int p = 0; p < 2; p++) begin
            measurePeriod(-1, 4'd0, 8'd0, 1'b0);
            compared++;
            if (highs[0] !== 64) begin
                mismatched++;
                $display("[TB] FAIL static_duty64 p%0d: got %0d highs want 64", p, highs[0]);
            end
            compared++;
            if (PeriodStart !== 1'b1 || psExtra !== 0) begin
                mismatched++;
                $display("[TB] FAIL static_periodstart p%0d: got end=%b extra=%0d want end=1 extra=0",
                         p, PeriodStart, psExtra);
            end
        end
    endtask

    task automatic test_duty_extremes;
        writeReg(4'd0, 8'd0,   1'b0);
        writeReg(4'd1, 8'd255, 1'b0);
        writeReg(4'd2, 8'd1,   1'b0);
        writeReg(4'd3, 8'd128, 1'b0);
        waitPeriodStart(elapsed);
        measurePeriod(-1, 4'd0, 8'd0, 1'b0);
        expHighs = '{0, 256, 1, 128};
        for (int c = 0; c < 4; c++) begin
            compared++;
            if (highs[c] !== expHighs[c]) begin
                mismatched++;
                $display("[TB] FAIL extremes ch%0d: got %0d highs want %0d", c, highs[c], expHighs[c]);
            end
        end
    endtask

    task automatic test_midperiod_change;
        writeReg(4'd1, 8'd32, 1'b0);
        waitPeriodStart(elapsed);
        measurePeriod(100, 4'd1, 8'd200, 1'b0);
        compared++;
        if (highs[1] !== 32) begin
            mismatched++;
            $display("[TB] FAIL midperiod_current: got %0d highs want 32", highs[1]);
        end
        measurePeriod(-1, 4'd0, 8'd0, 1'b0);
        compared++;
        if (highs[1] !== 200) begin
            mismatched++;
            $display("[TB] FAIL midperiod_next: got %0d highs want 200", highs[1]);
        end
    endtask

    task automatic test_back_to_back;
        measurePeriod(255, 4'd3, 8'd10, 1'b0);
        measurePeriod(50, 4'd7, 8'd77, 1'b1);
        compared++;
        if (highs[3] !== 128) begin
            mismatched++;
            $display("[TB] FAIL boundary_write_late: got %0d highs want 128", highs[3]);
        end
        measurePeriod(-1, 4'd0, 8'd0, 1'b0);
        expHighs = '{0, 200, 1, 10};
        for (int c = 0; c < 4; c++) begin
            compared++;
            if (highs[c] !== expHighs[c]) begin
                mismatched++;
                $display("[TB] FAIL bad_chan_ignored ch%0d: got %0d highs want %0d", c, highs[c], expHighs[c]);
            end
        end
    endtask

    task automatic test_breathe;
        int seq [10];
        seq = '{1, 2, 3, 2, 1, 0, 1, 0, 0, 0};
        writeReg(4'd2, 8'd0, 1'b0);
        waitPeriodStart(elapsed);
        measurePeriod(20, 4'd2, 8'd3, 1'b1);
        compared++;
        if (highs[2] !== 0) begin
            mismatched++;
            $display("[TB] FAIL breathe_start: got %0d highs want 0", highs[2]);
        end
        for (int p = 0; p < 10; p++) begin
            if (p == 6) measurePeriod(20, 4'd2, 8'd0, 1'b1);
            else        measurePeriod(-1, 4'd0, 8'd0, 1'b0);
            compared++;
            if (highs[2] !== seq[p]) begin
                mismatched++;
                $display("[TB] FAIL breathe_step p%0d: got %0d highs want %0d", p, highs[2], seq[p]);
            end
        end
    endtask

    task automatic test_enable_hold;
        int holdHigh = 0;
        int enabledSamples = 0;
        logic [7:0] heldCount;
        for (int c = 0; c < 4; c++) highs[c] = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge SysClk);
            for (int c = 0; c < 4; c++) if (PWM[c]) highs[c]++;
            enabledSamples++;
        end
        Enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge SysClk);
            if (PWM !== 4'b0000) holdHigh++;
            heldCount = dut.count;
        end
        Enable = 1'b1;
        do begin
            @(negedge SysClk);
            for (int c = 0; c < 4; c++) if (PWM[c]) highs[c]++;
            enabledSamples++;
        end while (!PeriodStart && enabledSamples < 400);
        compared++;
        if (holdHigh !== 0) begin
            mismatched++;
            $display("[TB] FAIL hold_pwm_low: got %0d high samples want 0", holdHigh);
        end
        compared++;
        if (heldCount !== 8'd100) begin
            mismatched++;
            $display("[TB] FAIL hold_count: got %0d want 100", heldCount);
        end
        compared++;
        if (enabledSamples !== 256) begin
            mismatched++;
            $display("[TB] FAIL hold_resume_length: got %0d want 256", enabledSamples);
        end
        compared++;
        if (highs[1] !== 200 || highs[3] !== 10) begin
            mismatched++;
            $display("[TB] FAIL hold_duties: got ch1=%0d ch3=%0d want ch1=200 ch3=10", highs[1], highs[3]);
        end
    endtask

    task automatic test_reset_midperiod;
        int bad = 0;
        int anyHigh = 0;
        int pulses = 0;
        int firstAt = -1;
        repeat (50) @(negedge SysClk);
        ResetN    = 1'b0;
        wr.WrEn   = 1'b1;
        wr.WrChan = 4'd1;
        wr.WrDuty = 8'd255;
        wr.WrMode = 1'b1;
        @(negedge SysClk);
        compared++;
        if (PWM !== 4'b0000 || PeriodStart !== 1'b0 || dut.count !== 8'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_outputs: got PWM=%b PS=%b count=%0d want 0000/0/0",
                     PWM, PeriodStart, dut.count);
        end
        for (int c = 0; c < 4; c++) begin
            if (dut.shadowDuty[c] !== 8'd0 || dut.shadowMode[c] !== 1'b0 ||
                dut.activeDuty[c] !== 8'd0 || dut.dir[c] !== 1'b0) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("[TB] FAIL midreset_registers: got %0d channels not cleared want 0", bad);
        end
        ResetN  = 1'b1;
        wr.WrEn = 1'b0;
        for (int j = 1; j <= 600; j++) begin
            @(negedge SysClk);
            if (PWM !== 4'b0000) anyHigh++;
            if (PeriodStart) begin
                pulses++;
                if (firstAt < 0) firstAt = j;
            end
        end
        compared++;
        if (anyHigh !== 0) begin
            mismatched++;
            $display("[TB] FAIL postreset_pwm_low: got %0d high samples want 0", anyHigh);
        end
        compared++;
        if (pulses !== 2 || firstAt !== 256) begin
            mismatched++;
            $display("[TB] FAIL postreset_period: got pulses=%0d first=%0d want 2/256", pulses, firstAt);
        end
    endtask

    initial begin
        ResetN    = 1'b0;
        Enable    = 1'b0;
        wr.WrEn   = 1'b0;
        wr.WrChan = 4'd0;
        wr.WrDuty = 8'd0;
        wr.WrMode = 1'b0;
        @(negedge SysClk);
        test_reset();
        test_static_duty();
        test_duty_extremes();
        test_midperiod_change();
        test_back_to_back();
        test_breathe();
        test_enable_hold();
        test_reset_midperiod();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_led_array.md
PWM_LED_ARRAY -- requirements
Module: pwm_led_array

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent PWM outputs (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the duty/counter width; the period is 2^WIDTH clocks.
REQ-003 The block SHALL have port SysClk  input  1  system clock; all logic on its rising edge.
REQ-004 The block SHALL have port ResetN  input  1  reset; one clock, synchronous, active-low.
REQ-005 The block SHALL have port Enable  input  1  high runs the period counter; low freezes it and blanks outputs.
REQ-006 The block SHALL have port WrEn  input  1  single-cycle write strobe for one channel's settings.
REQ-007 The block SHALL have port WrChan  input  4  target channel index of the write.
REQ-008 The block SHALL have port WrDuty  input  WIDTH  duty value (static mode) or peak value (breathe mode).
REQ-009 The block SHALL have port WrMode  input  1  0 = static, 1 = breathe.
REQ-010 The block SHALL have port PWM  output  CHANNELS  registered PWM outputs, bit i = channel i.
REQ-011 The block SHALL have port PeriodStart  output  1  registered one-cycle pulse at the first clock of each period.

Function
REQ-012 A shared counter Count SHALL increment by 1 each clock while Enable=1, wrap from 2^WIDTH-1 to 0, and hold while Enable=0.
REQ-013 Each channel SHALL hold a Shadow register (duty, mode) and an Active register (duty); the Active duty alone drives the output.
REQ-014 When WrEn=1 and WrChan<CHANNELS, Shadow[WrChan] SHALL load {WrDuty, WrMode} at that clock edge; when WrChan>=CHANNELS the write SHALL be ignored.
REQ-015 Boundary = the clock where Enable=1 and Count=2^WIDTH-1; Active registers and channel modes SHALL update only at a boundary.
REQ-016 Static mode at a boundary: Active[i] SHALL load Shadow duty[i].
REQ-017 Breathe mode SHALL hold a per-channel direction flag Dir (up/down); at each boundary Active steps by exactly 1.
REQ-018 Breathe, Dir=up: if Active>=peak then Dir<=down and Active<=Active-1 (hold if Active=0); else Active<=Active+1.
REQ-019 Breathe, Dir=down: if Active=0 then Dir<=up and Active<=1 (hold at 0 if peak=0); else Active<=Active-1.
REQ-020 On a static-to-breathe mode change at a boundary, Dir SHALL be set up and stepping SHALL start from the current Active value.
REQ-021 Write and boundary in the same clock: the boundary SHALL use the previous Shadow contents; the new write SHALL take effect at the next boundary.
REQ-022 PWM[i] SHALL be registered: PWM[i] <= Enable & ((Active[i]=2^WIDTH-1) | (Count<Active[i])), i.e. one clock latency from Count.
REQ-023 Duty 0 SHALL give a constant-low output, duty 2^WIDTH-1 a constant-high output, and any other duty D exactly D high clocks per period.
REQ-024 PeriodStart SHALL be 1 for exactly the one clock following each boundary and 0 otherwise.
REQ-025 Enable=0 SHALL force PWM to 0 on the next clock while holding Count, Shadow, Active, and Dir; Enable=1 SHALL resume from the held Count.
REQ-026 Writes SHALL be accepted whether Enable is 0 or 1.

Reset
REQ-027 ResetN=0 at a clock edge SHALL set Count=0, all Shadow duty=0 and mode=static, all Active=0, all Dir=up, PWM=0, and PeriodStart=0.
REQ-028 Reset SHALL override a simultaneous write, boundary, or Enable, and reset mid-period SHALL abandon the current period with no glitch pulse on PWM.
REQ-029 After ResetN returns to 1, a new period SHALL start at Count=0 and all outputs SHALL stay low until written duty values reach Active at a boundary.

Verification (WIDTH=8, CHANNELS=4)
REQ-030 Scenario: write ch0 duty=64 static, Enable=1 -> from the second boundary, PWM[0] is high 64 and low 192 clocks per 256-clock period, and PeriodStart pulses every 256 clocks.
REQ-031 Scenario: duties 0, 255, 1, and 128 on ch0..3 -> PWM[0] is constant 0, PWM[1] is constant 1, PWM[2] is high 1 clock per period, and PWM[3] is high 128 clocks per period.
REQ-032 Scenario: ch1 duty changed 32->200 mid-period -> the current period keeps 32 high clocks, and the next period has 200.
REQ-033 Scenario: ch2 breathe with peak=3 starting from Active=0 -> per-period high counts are 1, 2, 3, 2, 1, 0, 1, and so on; with peak=0 the output stays constant 0.
REQ-034 Scenario: write coinciding with a boundary; write with WrChan=7 -> the first takes effect one period late, and the second changes no channel.
REQ-035 Scenario: Enable dropped for 10 clocks mid-period, then ResetN pulsed mid-period -> PWM is 0 during the hold and the period resumes with Count held; after reset all outputs and registers match REQ-027.
